// File: rtl/cnt_run_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cnt_run_ctrl_pkg                                              |
// | Purpose  : Shared definitions for the counter run controller: run-state  |
// |            encodings and default datapath widths.                        |
// | Contents : cnt_state_e (IDLE=0, RUN=1, PAUSE=2, DONE=3), CW_DEF, PW_DEF  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cnt_run_ctrl_pkg;

    localparam int unsigned CW_DEF = 6;
    localparam int unsigned PW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } cnt_state_e;

endpackage
`default_nettype wire

// File: rtl/cnt_run_ctrl_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cnt_prescaler                                                 |
// | Purpose  : Divides enabled clk cycles by a programmable period and flags |
// |            the cycle on which a count step is due.                       |
// | Ports    : clk, rst (async, active-high)                                 |
// |            en      - advance the divider this cycle                      |
// |            clr     - force the divider back to 0 (wins over en)          |
// |            period  - cycles per step; 0 and 1 both mean every en cycle   |
// |            step    - high when en is set and this is the last cycle of   |
// |                      the period (combinational)                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cnt_prescaler
    import cnt_run_ctrl_pkg::*;
#(
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] period,
    output logic          step
);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    // ">=" rather than "==" so a stale count can never run past the period.
    assign w_last = (period <= PW'(1)) || (r_cnt >= (period - PW'(1)));
    assign step   = en & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cnt_run_ctrl                                                  |
// | Purpose  : Run controller for the counter datapath. Sequences start,     |
// |            pause, stop and clear, paces steps through cnt_prescaler and  |
// |            counts up or down between 0 and a latched limit with either   |
// |            wrap-around or stop-at-end.                                   |
// | Ports    : clk, rst (async, active-high)                                 |
// |            num        - clk cycles per step (latched at start)           |
// |            cmd_start/cmd_pause/cmd_stop/cmd_clear - 1-cycle commands,    |
// |                         priority clear > stop > start > pause            |
// |            dir, wrap, limit - direction/end mode/terminal (at start)     |
// |            load_val   - start value                                      |
// |            out        - current count          (registered)              |
// |            tick, done - step / terminal pulses  (registered)             |
// |            busy       - RUN or PAUSE                                     |
// |            state      - IDLE=0 RUN=1 PAUSE=2 DONE=3 (registered)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cnt_run_ctrl
    import cnt_run_ctrl_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] num,
    input  logic          cmd_start,
    input  logic          cmd_pause,
    input  logic          cmd_stop,
    input  logic          cmd_clear,
    input  logic          dir,
    input  logic          wrap,
    input  logic [CW-1:0] load_val,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] out,
    output logic          tick,
    output logic          done,
    output logic          busy,
    output logic [1:0]    state
);

    cnt_state_e    r_state;
    cnt_state_e    w_state_nxt;
    logic [CW-1:0] r_out;
    logic [CW-1:0] w_out_nxt;
    logic          r_tick;
    logic          w_tick_nxt;
    logic          r_done;
    logic          w_done_nxt;

    logic [PW-1:0] r_num_q;
    logic          r_dir_q;
    logic          r_wrap_q;
    logic [CW-1:0] r_limit_q;

    logic          w_load;
    logic          w_pre_en;
    logic          w_pre_clr;
    logic          w_step;
    logic          w_terminal;

    // Any of the three higher-priority commands restarts the divider from 0.
    assign w_pre_clr = cmd_clear | cmd_stop | cmd_start;

    // The divider counts on every RUN edge and also on the resume edge out of
    // PAUSE, so a pause/resume pair costs exactly one counting edge in total.
    assign w_pre_en = ~w_pre_clr &
                      (((r_state == ST_RUN)   & ~cmd_pause) |
                       ((r_state == ST_PAUSE) &  cmd_pause));

    cnt_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (w_pre_en),
        .clr    (w_pre_clr),
        .period (r_num_q),
        .step   (w_step)
    );

    // Up mode never holds a value above limit (start clamps it), so >= is
    // equivalent to reaching the limit.
    assign w_terminal = r_dir_q ? (r_out == '0) : (r_out >= r_limit_q);

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;

        if (cmd_clear) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
        end else if (cmd_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (cmd_start) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
            if (!dir && (load_val > limit)) begin
                w_out_nxt = limit;
            end else begin
                w_out_nxt = load_val;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (cmd_pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                end
            endcase

            // w_step already implies the divider was enabled this edge.
            if (w_step) begin
                w_tick_nxt = 1'b1;
                if (!w_terminal) begin
                    w_out_nxt = r_dir_q ? (r_out - CW'(1)) : (r_out + CW'(1));
                end else begin
                    w_done_nxt = 1'b1;
                    if (r_wrap_q) begin
                        w_out_nxt = r_dir_q ? r_limit_q : '0;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_out     <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_num_q   <= '0;
            r_dir_q   <= 1'b0;
            r_wrap_q  <= 1'b0;
            r_limit_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_num_q   <= num;
                r_dir_q   <= dir;
                r_wrap_q  <= wrap;
                r_limit_q <= limit;
            end
        end
    end

    assign out   = r_out;
    assign tick  = r_tick;
    assign done  = r_done;
    assign state = r_state;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_cnt_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cnt_run_ctrl                                               |
// | Purpose  : Directed self-checking bench for cnt_run_ctrl.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cnt_run_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] num;
    logic        cmd_start;
    logic        cmd_pause;
    logic        cmd_stop;
    logic        cmd_clear;
    logic        dir;
    logic        wrap;
    logic [5:0]  load_val;
    logic [5:0]  limit;
    logic [5:0]  out;
    logic        tick;
    logic        done;
    logic        busy;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cnt_run_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .cmd_start (cmd_start),
        .cmd_pause (cmd_pause),
        .cmd_stop  (cmd_stop),
        .cmd_clear (cmd_clear),
        .dir       (dir),
        .wrap      (wrap),
        .load_val  (load_val),
        .limit     (limit),
        .out       (out),
        .tick      (tick),
        .done      (done),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        step_clk();
        cmd_start = 1'b0;
    endtask

    task automatic pulse_pause();
        cmd_pause = 1'b1;
        step_clk();
        cmd_pause = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        step_clk();
        cmd_stop = 1'b0;
    endtask

    initial begin
        int ticks_seen;
        logic [5:0] seq2 [7];
        logic [5:0] prev;

        rst = 1'b1; num = '0; cmd_start = 0; cmd_pause = 0; cmd_stop = 0; cmd_clear = 0;
        dir = 0; wrap = 0; load_val = '0; limit = '0;
        repeat (2) step_clk();
        check("rst_out",   out,   0);
        check("rst_state", state, 0);
        check("rst_busy",  busy,  0);
        check("rst_tick",  tick,  0);
        check("rst_done",  done,  0);
        rst = 1'b0;
        step_clk();
        check("idle_state", state, 0);

        // 1: up, no wrap, 0..5 with a step every 4 cycles, then DONE
        num = 4; dir = 0; wrap = 0; load_val = 0; limit = 5;
        pulse_start();
        check("t1_load_out",   out,   0);
        check("t1_load_state", state, 1);
        check("t1_load_busy",  busy,  1);
        check("t1_load_tick",  tick,  0);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) step_clk();
            check("t1_pre_tick", tick, 0);
            step_clk();
            check("t1_step_out",  out,  k);
            check("t1_step_tick", tick, 1);
        end
        repeat (3) step_clk();
        check("t1_pre_done", done, 0);
        step_clk();
        check("t1_done",       done,  1);
        check("t1_done_state", state, 3);
        check("t1_done_out",   out,   5);
        ticks_seen = 0;
        repeat (8) begin
            step_clk();
            if (tick) ticks_seen++;
        end
        check("t1_after_ticks", ticks_seen, 0);
        check("t1_after_out",   out,   5);
        check("t1_after_busy",  busy,  0);

        // 2: down, wrap, one step per cycle from 2 with limit 3
        num = 1; dir = 1; wrap = 1; load_val = 2; limit = 3;
        seq2[0] = 1; seq2[1] = 0; seq2[2] = 3; seq2[3] = 2;
        seq2[4] = 1; seq2[5] = 0; seq2[6] = 3;
        pulse_start();
        check("t2_load_out", out, 2);
        prev = 2;
        for (int i = 0; i < 7; i++) begin
            step_clk();
            check("t2_out",  out,  seq2[i]);
            check("t2_done", done, (prev == 0) ? 1 : 0);
            check("t2_tick", tick, 1);
            prev = seq2[i];
        end
        check("t2_state", state, 1);
        pulse_stop();
        check("t2_stop_state", state, 0);
        check("t2_stop_out",   out,   3);

        // 3: pause with divider at 6 of 10, resume, step 3 edges later
        num = 10; dir = 0; wrap = 0; load_val = 0; limit = 63;
        pulse_start();
        repeat (20) step_clk();
        check("t3_out2",  out,  2);
        check("t3_tick2", tick, 1);
        repeat (6) step_clk();
        pulse_pause();
        check("t3_paused_state", state, 2);
        check("t3_paused_busy",  busy,  1);
        ticks_seen = 0;
        repeat (20) begin
            step_clk();
            if (tick) ticks_seen++;
        end
        check("t3_frozen_ticks", ticks_seen, 0);
        check("t3_frozen_out",   out,   2);
        pulse_pause();
        check("t3_resume_state", state, 1);
        check("t3_resume_tick",  tick,  0);
        step_clk();
        check("t3_r1_tick", tick, 0);
        step_clk();
        check("t3_r2_tick", tick, 0);
        step_clk();
        check("t3_r3_tick", tick, 1);
        check("t3_r3_out",  out,  3);

        // 4: clear and start in the same cycle while running
        cmd_clear = 1'b1; cmd_start = 1'b1;
        step_clk();
        cmd_clear = 1'b0; cmd_start = 1'b0;
        check("t4_state", state, 0);
        check("t4_out",   out,   0);
        check("t4_tick",  tick,  0);
        check("t4_done",  done,  0);

        // 5: up start above limit clamps, first step is terminal and wraps
        num = 3; dir = 0; wrap = 1; load_val = 50; limit = 20;
        pulse_start();
        check("t5_clamp", out, 20);
        repeat (2) step_clk();
        check("t5_pre_tick", tick, 0);
        step_clk();
        check("t5_done",  done,  1);
        check("t5_tick",  tick,  1);
        check("t5_out",   out,   0);
        check("t5_state", state, 1);
        pulse_stop();

        // 6: num change while busy is ignored; async reset mid-run
        num = 8; dir = 0; wrap = 0; load_val = 0; limit = 63;
        pulse_start();
        num = 2;
        repeat (7) step_clk();
        check("t6_pre_tick", tick, 0);
        check("t6_pre_out",  out,  0);
        step_clk();
        check("t6_s1_out", out, 1);
        repeat (7) step_clk();
        check("t6_gap_tick", tick, 0);
        step_clk();
        check("t6_s2_out",  out,  2);
        check("t6_s2_tick", tick, 1);
        step_clk();
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_out",   out,   0);
        check("t6_arst_state", state, 0);
        check("t6_arst_busy",  busy,  0);
        #1;
        rst = 1'b0;
        repeat (10) step_clk();
        check("t6_post_out",   out,   0);
        check("t6_post_state", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
